// File: rtl/a51_keystream_ctrl.sv
// rtl/a51_keystream_ctrl.sv - A5/1 session sequencer driving three external LFSRs; A51_ABORT_EN adds an abort input
module a51_keystream_ctrl #(
    parameter int KS_LEN      = 228,
    parameter int WARM_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    input  logic [0:18] x1,
    input  logic [0:21] x2,
    input  logic [0:22] x3,
`ifdef A51_ABORT_EN
    input  logic        abort,
`endif
    output logic        trig1,
    output logic        trig2,
    output logic        trig3,
    output logic        sb1,
    output logic        sb2,
    output logic        sb3,
    output logic        ks_bit,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_KEY, S_FRAME, S_WARM, S_GEN} state_t;

    localparam logic [7:0] WARM_LAST = 8'(WARM_CYCLES - 1);
    localparam logic [9:0] KS_LEN_W  = 10'(KS_LEN);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [9:0]  issued, issued_nxt;
    logic [9:0]  delivered, delivered_nxt;
    logic [63:0] key_q, key_nxt;
    logic [21:0] frame_q, frame_nxt;
    logic        ks_valid_q, ks_valid_nxt;
    logic        done_q, done_nxt;
    logic        abort_w;

    logic        c1, c2, c3, maj;
    logic        fb1, fb2, fb3;
    logic        step;
    logic        unused_x;

`ifdef A51_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign unused_x = ^{x1[0:7], x1[9:12], x1[14:15], x2[0:9], x2[11:19],
                        x3[0:6], x3[8:9], x3[11:19]};

    // Feeding each register its own taps inserts zeros, flushing it in 23 cycles.
    assign fb1 = x1[13] ^ x1[16] ^ x1[17] ^ x1[18];
    assign fb2 = x2[20] ^ x2[21];
    assign fb3 = x3[7] ^ x3[20] ^ x3[21] ^ x3[22];

    assign c1  = x1[8];
    assign c2  = x2[10];
    assign c3  = x3[10];
    assign maj = (c1 & c2) | (c1 & c3) | (c2 & c3);

    assign ks_bit   = x1[18] ^ x2[21] ^ x3[22];
    assign ks_valid = ks_valid_q;
    assign done     = done_q;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        issued_nxt    = issued;
        delivered_nxt = delivered;
        key_nxt       = key_q;
        frame_nxt     = frame_q;
        ks_valid_nxt  = ks_valid_q;
        done_nxt      = 1'b0;
        step          = 1'b0;
        trig1         = 1'b0;
        trig2         = 1'b0;
        trig3         = 1'b0;
        sb1           = 1'b0;
        sb2           = 1'b0;
        sb3           = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    key_nxt       = key;
                    frame_nxt     = frame;
                    cnt_nxt       = 8'd0;
                    issued_nxt    = 10'd0;
                    delivered_nxt = 10'd0;
                    ks_valid_nxt  = 1'b0;
                    state_nxt     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                {trig1, trig2, trig3} = 3'b111;
                sb1 = fb1;
                sb2 = fb2;
                sb3 = fb3;
                cnt_nxt = cnt + 8'd1;
                if (cnt == 8'd22) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_KEY;
                end
            end
            S_KEY: begin
                {trig1, trig2, trig3} = 3'b111;
                sb1 = key_q[cnt[5:0]];
                sb2 = key_q[cnt[5:0]];
                sb3 = key_q[cnt[5:0]];
                cnt_nxt = cnt + 8'd1;
                if (cnt == 8'd63) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_FRAME;
                end
            end
            S_FRAME: begin
                {trig1, trig2, trig3} = 3'b111;
                sb1 = frame_q[cnt[4:0]];
                sb2 = frame_q[cnt[4:0]];
                sb3 = frame_q[cnt[4:0]];
                cnt_nxt = cnt + 8'd1;
                if (cnt == 8'd21) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_WARM;
                end
            end
            S_WARM: begin
                trig1 = (c1 == maj);
                trig2 = (c2 == maj);
                trig3 = (c3 == maj);
                cnt_nxt = cnt + 8'd1;
                if (cnt == WARM_LAST) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                // Step only when the output slot is free or being drained this cycle.
                step = (!ks_valid_q || ks_ready) && (issued < KS_LEN_W);
                if (step) begin
                    trig1        = (c1 == maj);
                    trig2        = (c2 == maj);
                    trig3        = (c3 == maj);
                    issued_nxt   = issued + 10'd1;
                    ks_valid_nxt = 1'b1;
                end else if (ks_ready) begin
                    ks_valid_nxt = 1'b0;
                end
                if (ks_valid_q && ks_ready) begin
                    delivered_nxt = delivered + 10'd1;
                    if (delivered == KS_LEN_W - 10'd1) begin
                        ks_valid_nxt = 1'b0;
                        done_nxt     = 1'b1;
                        state_nxt    = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (abort_w && state != S_IDLE) begin
            trig1        = 1'b0;
            trig2        = 1'b0;
            trig3        = 1'b0;
            ks_valid_nxt = 1'b0;
            done_nxt     = 1'b0;
            state_nxt    = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            issued     <= 10'd0;
            delivered  <= 10'd0;
            key_q      <= 64'd0;
            frame_q    <= 22'd0;
            ks_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            issued     <= issued_nxt;
            delivered  <= delivered_nxt;
            key_q      <= key_nxt;
            frame_q    <= frame_nxt;
            ks_valid_q <= ks_valid_nxt;
            done_q     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// tb/tb_a51_keystream_ctrl.sv - randomized self-checking bench for a51_keystream_ctrl with LFSR models and A5/1 reference
module tb_a51_keystream_ctrl;

    localparam logic [63:0]  KV_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0]  KV_FRAME = 22'h000134;
    localparam logic [119:0] KV_A     = 120'h534EAA582FE8151AB6E1855A728C00;
    localparam logic [119:0] KV_B     = 120'h24FD35A35D5FB6526D32F906DF1AC0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key = '0;
    logic [21:0] frame = '0;
    logic [0:18] x1;
    logic [0:21] x2;
    logic [0:22] x3;
    logic        trig1, trig2, trig3, sb1, sb2, sb3;
    logic        ks_bit, ks_valid, busy, done;
    logic        ks_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [227:0] got_vec;
    logic [227:0] kv_exp;
    int           nbits, done_cyc, first_valid, stall_viol;
    logic         busy_at_done;
    bit           timed_out;

    always #5 clk = ~clk;

    a51_keystream_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key), .frame(frame),
        .x1(x1), .x2(x2), .x3(x3),
        .trig1(trig1), .trig2(trig2), .trig3(trig3),
        .sb1(sb1), .sb2(sb2), .sb3(sb3),
        .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .busy(busy), .done(done)
    );

    // Plain-datapath LFSRs sharing the design's reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
        end else begin
            if (trig1) x1 <= {x1[13] ^ x1[16] ^ x1[17] ^ x1[18] ^ sb1, x1[0:17]};
            if (trig2) x2 <= {x2[20] ^ x2[21] ^ sb2, x2[0:20]};
            if (trig3) x3 <= {x3[7] ^ x3[20] ^ x3[21] ^ x3[22] ^ sb3, x3[0:21]};
        end
    end

    // Reference A5/1: registers as integers, bit 0 is the newest bit.
    function automatic logic [227:0] ref_ks(input logic [63:0] k, input logic [21:0] f);
        logic [18:0]  a;
        logic [21:0]  b;
        logic [22:0]  c;
        logic [227:0] o;
        logic         m;
        a = '0; b = '0; c = '0; o = '0;
        for (int i = 0; i < 86; i++) begin
            logic in_bit;
            in_bit = (i < 64) ? k[i] : f[i - 64];
            a = {a[17:0], ^(a & 19'h72000)};
            b = {b[20:0], ^(b & 22'h300000)};
            c = {c[21:0], ^(c & 23'h700080)};
            a[0] = a[0] ^ in_bit;
            b[0] = b[0] ^ in_bit;
            c[0] = c[0] ^ in_bit;
        end
        for (int i = 0; i < 328; i++) begin
            m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
            if (a[8] == m)  a = {a[17:0], ^(a & 19'h72000)};
            if (b[10] == m) b = {b[20:0], ^(b & 22'h300000)};
            if (c[10] == m) c = {c[21:0], ^(c & 23'h700080)};
            if (i >= 100) o[i - 100] = a[18] ^ b[21] ^ c[22];
        end
        return o;
    endfunction

    task automatic run_session(input logic [63:0] k, input logic [21:0] f,
                               input bit rnd, input bit inject);
        int cyc;
        key = k;
        frame = f;
        got_vec = '0;
        nbits = 0;
        done_cyc = 0;
        first_valid = 0;
        stall_viol = 0;
        busy_at_done = 1'b1;
        timed_out = 0;
        cyc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (ks_valid && first_valid == 0) first_valid = cyc;
            if (ks_valid && ks_ready) begin
                if (nbits < 228) got_vec[nbits] = ks_bit;
                nbits++;
            end
            if (ks_valid && !ks_ready && (trig1 || trig2 || trig3)) stall_viol++;
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
                break;
            end
            if (cyc >= 5000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = inject && (cyc == 150 || cyc == 300);
        end
        start = 1'b0;
        ks_ready = 1'b1;
        tests++;
        if (timed_out) begin
            fails++;
            $display("FAIL session_timeout: no done within %0d cycles, bits=%0d", cyc, nbits);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (ks_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ks_valid); end
        tests++; if ({trig1, trig2, trig3} !== 3'b000) begin
            fails++; $display("FAIL reset_trig: got %b want 000", {trig1, trig2, trig3}); end
    endtask

    task automatic test_known_vector;
        logic [227:0] model;
        run_session(KV_KEY, KV_FRAME, 1'b0, 1'b0);
        model = ref_ks(KV_KEY, KV_FRAME);
        tests++; if (nbits !== 228) begin fails++; $display("FAIL kv_count: got %0d want 228", nbits); end
        tests++; if ({got_vec[0], got_vec[1], got_vec[2], got_vec[3], got_vec[4], got_vec[5], got_vec[6], got_vec[7]} !== 8'h53) begin
            fails++; $display("FAIL kv_first8: got %h want 53",
                {got_vec[0], got_vec[1], got_vec[2], got_vec[3], got_vec[4], got_vec[5], got_vec[6], got_vec[7]}); end
        tests++; if (got_vec[113:0] !== kv_exp[113:0]) begin
            fails++; $display("FAIL kv_block_a: got %h want %h", got_vec[113:0], kv_exp[113:0]); end
        tests++; if (got_vec[227:114] !== kv_exp[227:114]) begin
            fails++; $display("FAIL kv_block_b: got %h want %h", got_vec[227:114], kv_exp[227:114]); end
        tests++; if (got_vec !== model) begin fails++; $display("FAIL kv_model: got %h want %h", got_vec, model); end
        tests++; if (first_valid !== 211) begin fails++; $display("FAIL kv_first_valid: got %0d want 211", first_valid); end
        tests++; if (done_cyc !== 439) begin fails++; $display("FAIL kv_done_cycle: got %0d want 439", done_cyc); end
        tests++; if (busy_at_done !== 1'b0) begin fails++; $display("FAIL kv_busy_at_done: got %b want 0", busy_at_done); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL kv_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_random_ready;
        run_session(KV_KEY, KV_FRAME, 1'b1, 1'b0);
        tests++; if (nbits !== 228) begin fails++; $display("FAIL rr_count: got %0d want 228", nbits); end
        tests++; if (got_vec !== kv_exp) begin fails++; $display("FAIL rr_bits: got %h want %h", got_vec, kv_exp); end
        tests++; if (stall_viol !== 0) begin fails++; $display("FAIL rr_stall_trig: got %0d want 0", stall_viol); end
    endtask

    task automatic test_start_ignored;
        run_session(KV_KEY, KV_FRAME, 1'b0, 1'b1);
        tests++; if (got_vec !== kv_exp) begin fails++; $display("FAIL si_bits: got %h want %h", got_vec, kv_exp); end
        tests++; if (done_cyc !== 439) begin fails++; $display("FAIL si_done_cycle: got %0d want 439", done_cyc); end
    endtask

    task automatic test_reset_mid;
        key = KV_KEY;
        frame = KV_FRAME;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (149) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        tests++; if ({busy, ks_valid, done} !== 3'b000) begin
            fails++; $display("FAIL rm_outputs: got busy/valid/done %b want 000", {busy, ks_valid, done}); end
        tests++; if ({trig1, trig2, trig3} !== 3'b000) begin
            fails++; $display("FAIL rm_trig: got %b want 000", {trig1, trig2, trig3}); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_session(KV_KEY, KV_FRAME, 1'b0, 1'b0);
        tests++; if (got_vec !== kv_exp) begin fails++; $display("FAIL rm_rerun: got %h want %h", got_vec, kv_exp); end
    endtask

    task automatic test_back_to_back;
        logic [227:0] first, second, model2;
        run_session(KV_KEY, 22'h000134, 1'b1, 1'b0);
        first = got_vec;
        run_session(KV_KEY, 22'h000135, 1'b1, 1'b0);
        second = got_vec;
        model2 = ref_ks(KV_KEY, 22'h000135);
        tests++; if (second !== model2) begin fails++; $display("FAIL b2b_second: got %h want %h", second, model2); end
        tests++; if (second[31:0] === first[31:0]) begin
            fails++; $display("FAIL b2b_differ: got %h want different from %h", second[31:0], first[31:0]); end
        run_session(KV_KEY, 22'h000134, 1'b0, 1'b0);
        tests++; if (got_vec !== first) begin fails++; $display("FAIL b2b_rerun: got %h want %h", got_vec, first); end
    endtask

    task automatic test_random_sessions;
        logic [63:0]  k;
        logic [21:0]  f;
        logic [227:0] model;
        for (int i = 0; i < 3; i++) begin
            k = {$urandom, $urandom};
            f = 22'($urandom);
            model = ref_ks(k, f);
            run_session(k, f, 1'b1, 1'b0);
            tests++; if (got_vec !== model) begin
                fails++; $display("FAIL rand_session%0d: got %h want %h", i, got_vec, model); end
            tests++; if (stall_viol !== 0) begin
                fails++; $display("FAIL rand_stall%0d: got %0d want 0", i, stall_viol); end
        end
    endtask

    initial begin
        logic [119:0] ca, cb;
        ca = KV_A;
        cb = KV_B;
        for (int i = 0; i < 114; i++) begin
            kv_exp[i]       = ca[119 - i];
            kv_exp[114 + i] = cb[119 - i];
        end
        test_reset();
        test_known_vector();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random_sessions();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
